// File: rtl/icache_prefetch_unit_pkg.sv
// Shared fetch-address definitions for the instruction prefetch path.
// FETCH_ADDR_W / RESET_VECTOR are also consumed by the CPU core so both agree
// on the boot fetch address. pf_state_e encodes {req_active, abort} directly.
package icache_prefetch_unit_pkg;

    localparam int                      FETCH_ADDR_W = 20;
    localparam logic [FETCH_ADDR_W-1:0] RESET_VECTOR = 20'hFFFF0;

    // bit1 = request outstanding, bit0 = outstanding data will be discarded
    typedef enum logic [1:0] {
        PF_IDLE  = 2'b00,
        PF_REQ   = 2'b10,
        PF_ABORT = 2'b11
    } pf_state_e;

    // Start of the following 16-bit word; wraps from the top of memory to 0.
    function automatic logic [FETCH_ADDR_W-1:0] next_word_addr(
        input logic [FETCH_ADDR_W-1:0] a
    );
        logic [FETCH_ADDR_W-2:0] w;
        w = a[FETCH_ADDR_W-1:1] + {{(FETCH_ADDR_W-2){1'b0}}, 1'b1};
        return {w, 1'b0};
    endfunction

endpackage

// File: rtl/icache_prefetch_unit_fifo.sv
// prefetch_byte_fifo: DEPTH-entry byte ring buffer.
// Ports:
//   clk, reset      clock, async active-high reset
//   clr             synchronous clear of pointers and count (wins over push/pop)
//   push_n          bytes to push this cycle (0, 1 or 2)
//   push_data       push_data[7:0] goes first, push_data[15:8] second
//   pop             drop head byte; ignored when empty
//   head_data       head byte, 8'h00 when empty
//   count, empty    occupancy
module prefetch_byte_fifo #(
    parameter  int DEPTH = 6,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic [1:0]    push_n,
    input  logic [15:0]   push_data,
    input  logic          pop,
    output logic [7:0]    head_data,
    output logic [CW-1:0] count,
    output logic          empty
);

    localparam logic [PW+1:0] DEPTH_W = DEPTH[PW+1:0];

    logic [DEPTH-1:0][7:0] mem_q;
    logic [PW-1:0]         head_q, tail_q;
    logic [CW-1:0]         count_q;
    logic                  pop_eff;

    // Pointer advance by 0..2 modulo DEPTH; one subtract suffices since p+n < 2*DEPTH.
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input logic [1:0] n);
        logic [PW+1:0] s;
        s = {2'b00, p} + {{PW{1'b0}}, n};
        if (s >= DEPTH_W) s = s - DEPTH_W;
        return s[PW-1:0];
    endfunction

    assign pop_eff = pop && (count_q != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (clr) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (pop_eff) head_q <= wrap_add(head_q, 2'd1);
            tail_q  <= wrap_add(tail_q, push_n);
            count_q <= count_q + CW'(push_n) - CW'(pop_eff);
        end
    end

    // Storage needs no reset: reads are masked while empty.
    always_ff @(posedge clk) begin
        if (!clr) begin
            if (push_n != 2'd0) mem_q[tail_q] <= push_data[7:0];
            if (push_n == 2'd2) mem_q[wrap_add(tail_q, 2'd1)] <= push_data[15:8];
        end
    end

    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = empty ? 8'h00 : mem_q[head_q];

endmodule

// File: rtl/icache_prefetch_unit.sv
// icache_prefetch_unit: requester on the I-cache fetch port. Walks a byte
// fetch address, issues word reads (hold until m_ack) and unpacks returned
// words into a byte FIFO drained by the decoder.
// Ports:
//   clk, reset        clock, async active-high reset
//   flush, new_addr   discard queued/in-flight bytes, restart at new_addr
//   m_addr, m_access  word address [19:1] (registered) and request strobe
//   m_data_in, m_ack  fetch data (low byte = even address) and completion
//   rd_en             pop head byte (ignored when empty)
//   rd_data, empty    head byte (8'h00 when empty), FIFO empty
module icache_prefetch_unit
    import icache_prefetch_unit_pkg::*;
#(
    parameter int                      DEPTH      = 6,
    parameter logic [FETCH_ADDR_W-1:0] RESET_ADDR = RESET_VECTOR
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [FETCH_ADDR_W-1:0] new_addr,
    output logic [FETCH_ADDR_W-2:0] m_addr,
    output logic                    m_access,
    input  logic [15:0]             m_data_in,
    input  logic                    m_ack,
    input  logic                    rd_en,
    output logic [7:0]              rd_data,
    output logic                    empty
);

    localparam int            CW         = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] ROOM_LIMIT = CW'(DEPTH - 2);

    pf_state_e               state_q, state_d;
    logic [FETCH_ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
    logic [FETCH_ADDR_W-2:0] m_addr_q, m_addr_d;
    logic [CW-1:0]           count, count_next;
    logic                    ack_v, accept, pop_eff;
    logic [1:0]              push_n;
    logic [15:0]             push_data;

    // An ack only means something while a request is outstanding.
    assign ack_v   = m_ack && (state_q != PF_IDLE);
    assign accept  = ack_v && (state_q == PF_REQ) && !flush;
    assign pop_eff = rd_en && !empty && !flush;

    // Odd fetch address: only the high byte of the word belongs to the stream.
    always_comb begin
        push_n    = 2'd0;
        push_data = m_data_in;
        if (accept) begin
            if (fetch_addr_q[0]) begin
                push_n    = 2'd1;
                push_data = {8'h00, m_data_in[15:8]};
            end else begin
                push_n    = 2'd2;
            end
        end
    end

    assign count_next = flush ? '0 : count + CW'(push_n) - CW'(pop_eff);

    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        m_addr_d     = m_addr_q;

        if (accept) fetch_addr_d = next_word_addr(fetch_addr_q);
        if (flush)  fetch_addr_d = new_addr;

        case (state_q)
            // A request cannot be withdrawn; a flush marks its data for discard.
            PF_REQ:   if (ack_v) state_d = PF_IDLE;
                      else if (flush) state_d = PF_ABORT;
            PF_ABORT: if (ack_v) state_d = PF_IDLE;
            default:  state_d = PF_IDLE;
        endcase

        // Issue only with 2 bytes of room left after this cycle's push/pop,
        // so the eventual push can never overflow.
        if (state_d == PF_IDLE && count_next <= ROOM_LIMIT) begin
            state_d  = PF_REQ;
            m_addr_d = fetch_addr_d[FETCH_ADDR_W-1:1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= PF_IDLE;
            fetch_addr_q <= RESET_ADDR;
            m_addr_q     <= '0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            m_addr_q     <= m_addr_d;
        end
    end

    assign m_access = (state_q != PF_IDLE) && !m_ack;
    assign m_addr   = m_addr_q;

    prefetch_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clr       (flush),
        .push_n    (push_n),
        .push_data (push_data),
        .pop       (rd_en),
        .head_data (rd_data),
        .count     (count),
        .empty     (empty)
    );

endmodule

// File: tb/tb_icache_prefetch_unit.sv
module tb_icache_prefetch_unit;

    localparam int DEPTH = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic [19:0] new_addr = '0;
    logic [18:0] m_addr;
    logic        m_access;
    logic [15:0] m_data_in = '0;
    logic        m_ack = 1'b0;
    logic        rd_en = 1'b0;
    logic [7:0]  rd_data;
    logic        empty;

    int checks = 0;
    int failures = 0;

    // Reference model: byte stream queue plus request bookkeeping.
    logic [7:0]  mq[$];
    int unsigned m_faddr;
    bit          m_out, m_disc;
    logic [18:0] m_word;

    always #5 clk = ~clk;

    icache_prefetch_unit #(.DEPTH(DEPTH), .RESET_ADDR(20'hFFFF0)) dut (
        .clk(clk), .reset(reset), .flush(flush), .new_addr(new_addr),
        .m_addr(m_addr), .m_access(m_access), .m_data_in(m_data_in),
        .m_ack(m_ack), .rd_en(rd_en), .rd_data(rd_data), .empty(empty)
    );

    task automatic model_reset();
        mq.delete();
        m_faddr = 32'hFFFF0;
        m_out = 0; m_disc = 0; m_word = '0;
    endtask

    task automatic model_update();
        bit ack_eff;
        ack_eff = m_out && m_ack;
        if (flush) mq.delete();
        else begin
            if (rd_en && mq.size() > 0) mq.delete(0);
            if (ack_eff && !m_disc) begin
                if (m_faddr % 2 == 0) mq.push_back(m_data_in[7:0]);
                mq.push_back(m_data_in[15:8]);
                m_faddr = ((m_faddr / 2 + 1) % (1 << 19)) * 2;
            end
        end
        if (flush) m_faddr = new_addr;
        if (ack_eff) begin m_out = 0; m_disc = 0; end
        if (flush && m_out) m_disc = 1;
        if (!m_out && mq.size() <= DEPTH - 2) begin
            m_out = 1;
            m_word = 19'(m_faddr / 2);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) model_update();
        #1;
        flush = 0; m_ack = 0; rd_en = 0;
    endtask

    task automatic apply_reset();
        reset = 1; flush = 0; m_ack = 0; rd_en = 0;
        repeat (2) @(posedge clk);
        model_reset();
        #1 reset = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (m_access !== 1'b0) begin failures++; $display("FAIL rst_access got=%b exp=0", m_access); end
        checks++; if (m_addr !== 19'h0) begin failures++; $display("FAIL rst_maddr got=%h exp=0", m_addr); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rst_empty got=%b exp=1", empty); end
        checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL rst_rd_data got=%h exp=00", rd_data); end
    endtask

    task automatic test_boot();
        apply_reset();
        @(negedge clk);
        checks++; if (m_access !== 1'b0) begin failures++; $display("FAIL boot_pre_access got=%b exp=0", m_access); end
        tick();
        @(negedge clk);
        checks++; if (m_access !== 1'b1) begin failures++; $display("FAIL boot_access got=%b exp=1", m_access); end
        checks++; if (m_addr !== 19'h7FFF8) begin failures++; $display("FAIL boot_maddr got=%h exp=7fff8", m_addr); end
        tick();
        m_ack = 1; m_data_in = 16'hEA90;
        @(negedge clk);
        checks++; if (m_access !== 1'b0) begin failures++; $display("FAIL boot_ack_drop got=%b exp=0", m_access); end
        tick();
        rd_en = 1;
        @(negedge clk);
        checks++; if (empty !== 1'b0) begin failures++; $display("FAIL boot_empty got=%b exp=0", empty); end
        checks++; if (rd_data !== 8'h90) begin failures++; $display("FAIL boot_byte0 got=%h exp=90", rd_data); end
        checks++; if (m_access !== 1'b1) begin failures++; $display("FAIL boot_reissue got=%b exp=1", m_access); end
        checks++; if (m_addr !== 19'h7FFF9) begin failures++; $display("FAIL boot_next_maddr got=%h exp=7fff9", m_addr); end
        tick();
        @(negedge clk);
        checks++; if (rd_data !== 8'hEA) begin failures++; $display("FAIL boot_byte1 got=%h exp=ea", rd_data); end
    endtask

    task automatic test_flush_odd();
        apply_reset();
        flush = 1; new_addr = 20'h01235;
        @(negedge clk);
        tick();
        @(negedge clk);
        checks++; if (m_access !== 1'b1) begin failures++; $display("FAIL odd_access got=%b exp=1", m_access); end
        checks++; if (m_addr !== 19'h0091A) begin failures++; $display("FAIL odd_maddr got=%h exp=0091a", m_addr); end
        tick();
        m_ack = 1; m_data_in = 16'hBBAA;
        @(negedge clk);
        tick();
        rd_en = 1;
        @(negedge clk);
        checks++; if (rd_data !== 8'hBB) begin failures++; $display("FAIL odd_byte got=%h exp=bb", rd_data); end
        checks++; if (m_addr !== 19'h0091B) begin failures++; $display("FAIL odd_next_maddr got=%h exp=0091b", m_addr); end
        checks++; if (m_access !== 1'b1) begin failures++; $display("FAIL odd_reissue got=%b exp=1", m_access); end
        tick();
        @(negedge clk);
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL odd_one_byte got=%b exp=1", empty); end
    endtask

    task automatic test_fill_no_pop();
        int reqs;
        bit pend;
        logic [15:0] dat;
        logic [7:0] eb[$];
        reqs = 0; pend = 0;
        apply_reset();
        for (int c = 0; c < 20; c++) begin
            dat = 16'($urandom);
            m_ack = pend; m_data_in = dat;
            if (pend) begin eb.push_back(dat[7:0]); eb.push_back(dat[15:8]); end
            @(negedge clk);
            if (m_access) reqs++;
            pend = m_access;
            tick();
        end
        @(negedge clk);
        checks++; if (reqs !== 3) begin failures++; $display("FAIL fill_reqs got=%0d exp=3", reqs); end
        checks++; if (m_access !== 1'b0) begin failures++; $display("FAIL fill_idle got=%b exp=0", m_access); end
        checks++; if (rd_data !== eb[0]) begin failures++; $display("FAIL fill_head got=%h exp=%h", rd_data, eb[0]); end
        tick();
        rd_en = 1;
        @(negedge clk);
        tick();
        rd_en = 1;
        @(negedge clk);
        checks++; if (m_access !== 1'b0) begin failures++; $display("FAIL fill_one_pop got=%b exp=0", m_access); end
        tick();
        @(negedge clk);
        checks++; if (m_access !== 1'b1) begin failures++; $display("FAIL fill_two_pop got=%b exp=1", m_access); end
        checks++; if (m_addr !== 19'h7FFFB) begin failures++; $display("FAIL fill_maddr got=%h exp=7fffb", m_addr); end
        checks++; if (rd_data !== eb[2]) begin failures++; $display("FAIL fill_byte2 got=%h exp=%h", rd_data, eb[2]); end
    endtask

    task automatic test_flush_pending();
        apply_reset();
        tick();
        flush = 1; new_addr = 20'h0ABCD;
        @(negedge clk);
        checks++; if (m_access !== 1'b1) begin failures++; $display("FAIL abort_flush_access got=%b exp=1", m_access); end
        tick();
        for (int c = 0; c < 4; c++) begin
            if (c == 1) begin flush = 1; new_addr = 20'h12345; end
            @(negedge clk);
            checks++; if (m_access !== 1'b1 || m_addr !== 19'h7FFF8 || empty !== 1'b1) begin
                failures++; $display("FAIL abort_hold c=%0d got acc=%b addr=%h empty=%b exp acc=1 addr=7fff8 empty=1", c, m_access, m_addr, empty);
            end
            tick();
        end
        m_ack = 1; m_data_in = 16'hC3C3;
        @(negedge clk);
        tick();
        @(negedge clk);
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL abort_drop got=%b exp=1", empty); end
        checks++; if (m_access !== 1'b1) begin failures++; $display("FAIL abort_reissue got=%b exp=1", m_access); end
        checks++; if (m_addr !== 19'h091A2) begin failures++; $display("FAIL abort_maddr got=%h exp=091a2", m_addr); end
    endtask

    task automatic test_wrap();
        apply_reset();
        flush = 1; new_addr = 20'hFFFFF;
        @(negedge clk);
        tick();
        @(negedge clk);
        checks++; if (m_addr !== 19'h7FFFF) begin failures++; $display("FAIL wrap_maddr got=%h exp=7ffff", m_addr); end
        tick();
        m_ack = 1; m_data_in = 16'h3412;
        @(negedge clk);
        tick();
        rd_en = 1;
        @(negedge clk);
        checks++; if (rd_data !== 8'h34) begin failures++; $display("FAIL wrap_byte got=%h exp=34", rd_data); end
        checks++; if (m_addr !== 19'h00000 || m_access !== 1'b1) begin
            failures++; $display("FAIL wrap_next got addr=%h acc=%b exp addr=00000 acc=1", m_addr, m_access);
        end
        tick();
        @(negedge clk);
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL wrap_one_byte got=%b exp=1", empty); end
    endtask

    task automatic test_flush_pop_ack();
        apply_reset();
        tick();
        m_ack = 1; m_data_in = 16'h1111;
        @(negedge clk);
        tick();
        flush = 1; new_addr = 20'h00100; rd_en = 1; m_ack = 1; m_data_in = 16'h2222;
        @(negedge clk);
        checks++; if (rd_data !== 8'h11) begin failures++; $display("FAIL fpa_pre got=%h exp=11", rd_data); end
        tick();
        @(negedge clk);
        checks++; if (empty !== 1'b1 || rd_data !== 8'h00) begin
            failures++; $display("FAIL fpa_cleared got empty=%b rd=%h exp empty=1 rd=00", empty, rd_data);
        end
        checks++; if (m_access !== 1'b1 || m_addr !== 19'h00080) begin
            failures++; $display("FAIL fpa_reissue got acc=%b addr=%h exp acc=1 addr=00080", m_access, m_addr);
        end
        tick();
        m_ack = 1; m_data_in = 16'h4433;
        @(negedge clk);
        tick();
        @(negedge clk);
        checks++; if (rd_data !== 8'h33 || empty !== 1'b0) begin
            failures++; $display("FAIL fpa_no_abort got rd=%h empty=%b exp rd=33 empty=0", rd_data, empty);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_rd;
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            flush     = ($urandom_range(0, 19) == 0);
            new_addr  = ($urandom_range(0, 3) == 0) ? 20'hFFFFF : 20'($urandom);
            rd_en     = $urandom_range(0, 1);
            m_ack     = m_out && ($urandom_range(0, 2) == 0);
            m_data_in = 16'($urandom);
            @(negedge clk);
            exp_rd = (mq.size() > 0) ? mq[0] : 8'h00;
            checks++;
            if (m_access !== (m_out && !m_ack) || m_addr !== m_word ||
                empty !== (mq.size() == 0) || rd_data !== exp_rd) begin
                failures++;
                if (failures <= 20)
                    $display("FAIL rand c=%0d got acc=%b addr=%h empty=%b rd=%h exp acc=%b addr=%h empty=%b rd=%h",
                             c, m_access, m_addr, empty, rd_data, m_out && !m_ack, m_word, mq.size() == 0, exp_rd);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        tick();
        m_ack = 1; m_data_in = 16'h5A5A;
        @(negedge clk);
        tick();
        @(negedge clk);
        checks++; if (m_access !== 1'b1 || empty !== 1'b0) begin
            failures++; $display("FAIL rmid_pre got acc=%b empty=%b exp acc=1 empty=0", m_access, empty);
        end
        #2 reset = 1;
        #1;
        checks++; if (m_access !== 1'b0 || m_addr !== 19'h0 || empty !== 1'b1) begin
            failures++; $display("FAIL rmid_async got acc=%b addr=%h empty=%b exp acc=0 addr=0 empty=1", m_access, m_addr, empty);
        end
    endtask

    initial begin
        test_reset();
        test_boot();
        test_flush_odd();
        test_fill_no_pop();
        test_flush_pending();
        test_wrap();
        test_flush_pop_ack();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
